// File: rtl/multi_channel_trigger_delay_generator.sv
// Periodic master trigger plus NUMBER_OF_CHANNELS delayed triggers with double-buffered, strobe-adjusted delays.
// Optional macro CHANNEL_MASK_EN adds a channel_mask input whose shadow copy is committed at the period boundary.
module multi_channel_trigger_delay_generator #(
    parameter int unsigned CLOCK_FREQUENCY_HZ   = 100000000,
    parameter int unsigned PERIOD_COUNTS        = CLOCK_FREQUENCY_HZ / 10,
    parameter int unsigned NUMBER_OF_CHANNELS   = 4,
    parameter int unsigned PULSE_WIDTH_COUNTS   = 1,
    parameter int unsigned DEFAULT_DELAY_COUNTS = CLOCK_FREQUENCY_HZ / 1000,
    parameter int unsigned DELAY_STEP_COUNTS    = CLOCK_FREQUENCY_HZ / 10000,
    parameter int unsigned MIN_DELAY_COUNTS     = 0,
    parameter int unsigned MAX_DELAY_COUNTS     = PERIOD_COUNTS - 1,
    parameter int unsigned COUNTER_WIDTH        = $clog2(PERIOD_COUNTS),
    parameter int unsigned SELECT_WIDTH         = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          increment,
    input  logic                          decrement,
    input  logic [SELECT_WIDTH-1:0]       channel_select,
`ifdef CHANNEL_MASK_EN
    input  logic [NUMBER_OF_CHANNELS-1:0] channel_mask,
`endif
    output logic                          master_trigger,
    output logic [NUMBER_OF_CHANNELS-1:0] channel_trigger,
    output logic [COUNTER_WIDTH-1:0]      selected_delay,
    output logic [7:0]                    trigger_count
);

    localparam int unsigned EXT_WIDTH     = COUNTER_WIDTH + 1;
    localparam int unsigned STRETCH_WIDTH = $clog2(PULSE_WIDTH_COUNTS + 1);

    localparam logic [COUNTER_WIDTH-1:0] LAST_PHASE    = COUNTER_WIDTH'(PERIOD_COUNTS - 1);
    localparam logic [COUNTER_WIDTH-1:0] DEFAULT_DELAY = COUNTER_WIDTH'(DEFAULT_DELAY_COUNTS);
    localparam logic [COUNTER_WIDTH-1:0] MIN_DELAY     = COUNTER_WIDTH'(MIN_DELAY_COUNTS);
    localparam logic [COUNTER_WIDTH-1:0] MAX_DELAY     = COUNTER_WIDTH'(MAX_DELAY_COUNTS);
    localparam logic [COUNTER_WIDTH-1:0] STEP          = COUNTER_WIDTH'(DELAY_STEP_COUNTS);
    localparam logic [EXT_WIDTH-1:0]     STEP_EXT      = EXT_WIDTH'(DELAY_STEP_COUNTS);
    localparam logic [EXT_WIDTH-1:0]     MAX_EXT       = EXT_WIDTH'(MAX_DELAY_COUNTS);
    localparam logic [EXT_WIDTH-1:0]     DEC_FLOOR     = EXT_WIDTH'(MIN_DELAY_COUNTS + DELAY_STEP_COUNTS);
    localparam logic [STRETCH_WIDTH-1:0] PULSE_RELOAD  = STRETCH_WIDTH'(PULSE_WIDTH_COUNTS - 1);

    logic [COUNTER_WIDTH-1:0]                          phase;
    logic [STRETCH_WIDTH-1:0]                          master_remaining;
    logic                                              master_start_c;
    logic                                              commit_c;
    logic [NUMBER_OF_CHANNELS-1:0]                     mask_shadow;
    logic [NUMBER_OF_CHANNELS-1:0][COUNTER_WIDTH-1:0]  pending_flat;

    assign master_start_c = enable && (phase == '0);
    // Delays (and mask) move to the active copy only at the period boundary, or freely while halted.
    assign commit_c       = !enable || (phase == LAST_PHASE);

    // Phase counter, master pulse stretcher and trigger counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase            <= '0;
            master_trigger   <= 1'b0;
            master_remaining <= '0;
            trigger_count    <= '0;
        end else if (!enable) begin
            phase            <= '0;
            master_trigger   <= 1'b0;
            master_remaining <= '0;
        end else begin
            phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
            if (master_start_c) begin
                master_trigger   <= 1'b1;
                master_remaining <= PULSE_RELOAD;
                trigger_count    <= trigger_count + 8'd1;
            end else if (master_remaining != '0) begin
                master_remaining <= master_remaining - 1'b1;
            end else begin
                master_trigger <= 1'b0;
            end
        end
    end

`ifdef CHANNEL_MASK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_shadow <= '0;
        end else if (commit_c) begin
            mask_shadow <= channel_mask;
        end
    end
`else
    assign mask_shadow = '0;
`endif

    for (genvar k = 0; k < NUMBER_OF_CHANNELS; k++) begin : g_channel
        logic [COUNTER_WIDTH-1:0] pending_delay;
        logic [COUNTER_WIDTH-1:0] active_delay;
        logic [STRETCH_WIDTH-1:0] remaining;
        logic                     pulse;
        logic [EXT_WIDTH-1:0]     pending_ext;
        logic [EXT_WIDTH-1:0]     inc_sum;
        logic [COUNTER_WIDTH-1:0] inc_value;
        logic [COUNTER_WIDTH-1:0] dec_value;
        logic                     hit_c;
        logic                     start_c;

        // One extra bit keeps the saturating add/subtract from wrapping.
        assign pending_ext = {1'b0, pending_delay};
        assign inc_sum     = pending_ext + STEP_EXT;
        assign inc_value   = (inc_sum > MAX_EXT) ? MAX_DELAY : inc_sum[COUNTER_WIDTH-1:0];
        assign dec_value   = (pending_ext < DEC_FLOOR) ? MIN_DELAY : pending_delay - STEP;
        assign hit_c       = (channel_select == SELECT_WIDTH'(k)) && (increment != decrement);
        assign start_c     = enable && (phase == active_delay) && !mask_shadow[k];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                pending_delay <= DEFAULT_DELAY;
                active_delay  <= DEFAULT_DELAY;
            end else begin
                if (hit_c) begin
                    pending_delay <= increment ? inc_value : dec_value;
                end
                if (commit_c) begin
                    active_delay <= pending_delay;
                end
            end
        end

        // Pulse stretcher; a new start restarts the full width.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                pulse     <= 1'b0;
                remaining <= '0;
            end else if (!enable) begin
                pulse     <= 1'b0;
                remaining <= '0;
            end else if (start_c) begin
                pulse     <= 1'b1;
                remaining <= PULSE_RELOAD;
            end else if (remaining != '0) begin
                remaining <= remaining - 1'b1;
            end else begin
                pulse <= 1'b0;
            end
        end

        assign channel_trigger[k] = pulse;
        assign pending_flat[k]    = pending_delay;
    end

    // Out-of-range selects read back as zero.
    always_comb begin
        selected_delay = '0;
        for (int unsigned k = 0; k < NUMBER_OF_CHANNELS; k++) begin
            if (channel_select == SELECT_WIDTH'(k)) begin
                selected_delay = pending_flat[k];
            end
        end
    end

endmodule
